// File: rtl/simplecpu_pkg.sv
// Shared opcode and state encodings for the parametrised accumulator CPU.
package simplecpu_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
  localparam logic [OPC_W-1:0] OP_OUT = 4'h8;
  localparam logic [OPC_W-1:0] OP_HLT = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC  = 4'hA;
  localparam logic [OPC_W-1:0] OP_JNZ = 4'hB;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StAlu   = 3'd3,
    StOutw  = 3'd4,
    StHalt  = 3'd5
  } state_e;

endpackage

// File: rtl/simplecpu_alu_param.sv
// Combinational add/subtract unit; carry=1 on subtract means no borrow.
module simplecpu_alu_param #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  end

  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];
  assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/simplecpu_pipe_param.sv
// Accumulator CPU with unified program/data memory, host load port and a
// valid/ready result stream. Requires DATA_W >= 4 + ADDR_W.
module simplecpu_pipe_param
  import simplecpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              halted,
  output logic              illegal,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OPC_W-1:0]  ir_op_q, ir_op_d;
  logic [ADDR_W-1:0] ir_arg_q, ir_arg_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              illegal_q, illegal_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  simplecpu_alu_param #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .sub   (ir_op_q == OP_SUB),
    .result(alu_result),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_op_d     = ir_op_q;
    ir_arg_d    = ir_arg_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr;
    mem_wdata   = load_data;

    case (state_q)
      StIdle, StHalt: begin
        // The host write lands on the same edge as run, so the first fetch sees it.
        mem_we = load_en;
        if (run) begin
          pc_d      = '0;
          a_d       = '0;
          b_d       = '0;
          zero_d    = 1'b0;
          carry_d   = 1'b0;
          illegal_d = 1'b0;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        ir_op_d  = mem[pc_q][DATA_W-1 -: OPC_W];
        ir_arg_d = mem[pc_q][ADDR_W-1:0];
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (ir_op_q)
          OP_NOP: ;
          OP_LDA: a_d = mem[ir_arg_q];
          OP_ADD, OP_SUB: begin
            b_d     = mem[ir_arg_q];
            state_d = StAlu;
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = ir_arg_q;
            mem_wdata = a_q;
          end
          OP_LDI: a_d = DATA_W'(ir_arg_q);
          OP_JMP: pc_d = ir_arg_q;
          OP_JZ:  if (zero_q) pc_d = ir_arg_q;
          OP_JC:  if (carry_q) pc_d = ir_arg_q;
          OP_JNZ: if (!zero_q) pc_d = ir_arg_q;
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
            state_d     = StOutw;
          end
          OP_HLT: state_d = StHalt;
          default: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StAlu: begin
        a_d     = alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        state_d = StFetch;
      end
      StOutw: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_op_q     <= '0;
      ir_arg_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_op_q     <= ir_op_d;
      ir_arg_q    <= ir_arg_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  // Memory survives reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pc         = pc_q;
  assign acc        = a_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;
  assign busy       = (state_q != StIdle) && (state_q != StHalt);

endmodule
